// File: rtl/rgmii_idelay_tuner.sv
// RGMII receive IDELAY tuner.
// Sweeps a common tap across all lanes, scores each tap per lane from qualified
// training-pattern matches, tracks the longest contiguous passing window per lane
// and finally loads each lane with the centre of its window.
module rgmii_idelay_tuner #(
  parameter int LANES         = 5,
  parameter int TAP_W         = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CNT    = 64,
  parameter int DEFAULT_TAP   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     dly_rdy,
  input  logic                     sample_valid,
  input  logic [LANES-1:0]         sample_ok,
  output logic [LANES*TAP_W-1:0]   tap_value,
  output logic [LANES-1:0]         tap_load,
  output logic                     busy,
  output logic                     done,
  output logic [LANES-1:0]         fail
);

  // Run lengths need one extra bit: a window can span every tap.
  localparam int RUN_W   = TAP_W + 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CNT) ? SETTLE_CYCLES : SAMPLE_CNT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [TAP_W-1:0] MAX_TAP     = '1;
  localparam logic [TAP_W-1:0] DEF_TAP     = TAP_W'(DEFAULT_TAP);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_SET_TAP,
    ST_SETTLE,
    ST_SAMPLE,
    ST_UPDATE,
    ST_APPLY,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   sweep_q, sweep_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LANES-1:0]   pass_q, pass_d;
  logic [LANES-1:0]   fail_q, fail_d;
  logic [TAP_W-1:0]   run_start_q  [LANES];
  logic [TAP_W-1:0]   run_start_d  [LANES];
  logic [RUN_W-1:0]   run_len_q    [LANES];
  logic [RUN_W-1:0]   run_len_d    [LANES];
  logic [TAP_W-1:0]   best_start_q [LANES];
  logic [TAP_W-1:0]   best_start_d [LANES];
  logic [RUN_W-1:0]   best_len_q   [LANES];
  logic [RUN_W-1:0]   best_len_d   [LANES];
  logic [TAP_W-1:0]   tap_q        [LANES];
  logic [TAP_W-1:0]   tap_d        [LANES];

  // Best window once a run still open at the last tap has been closed.
  logic [TAP_W-1:0]   cls_start    [LANES];
  logic [RUN_W-1:0]   cls_len      [LANES];
  logic [TAP_W-1:0]   apply_tap    [LANES];

  logic start_cal;
  logic abort;
  logic clear_rec;

  // Centre of a window, biased toward the start for even lengths.
  function automatic logic [TAP_W-1:0] center_tap(input logic [TAP_W-1:0] s,
                                                  input logic [RUN_W-1:0] len);
    if (len == '0) begin
      return DEF_TAP;
    end
    return TAP_W'({1'b0, s} + ((len - RUN_W'(1)) >> 1));
  endfunction

  assign start_cal = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign abort     = !dly_rdy && ((state_q == ST_SET_TAP) || (state_q == ST_SETTLE) ||
                                  (state_q == ST_SAMPLE)  || (state_q == ST_UPDATE));
  assign clear_rec = start_cal || abort;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        run_start_q[i]  <= '0;
        run_len_q[i]    <= '0;
        best_start_q[i] <= '0;
        best_len_q[i]   <= '0;
        tap_q[i]        <= DEF_TAP;
      end
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      cnt_q        <= cnt_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      tap_q        <= tap_d;
    end
  end

  // Next state: sweep sequencing, with delay-controller loss aborting the sweep.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_WAIT_RDY;
      ST_WAIT_RDY:      if (dly_rdy) state_d = ST_SET_TAP;
      ST_SET_TAP:       state_d = dly_rdy ? ST_SETTLE : ST_WAIT_RDY;
      ST_SETTLE: begin
        if (!dly_rdy)                  state_d = ST_WAIT_RDY;
        else if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (!dly_rdy)                                   state_d = ST_WAIT_RDY;
        else if (sample_valid && (cnt_q == SAMPLE_LAST)) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (!dly_rdy)                state_d = ST_WAIT_RDY;
        else if (sweep_q == MAX_TAP) state_d = ST_APPLY;
        else                         state_d = ST_SET_TAP;
      end
      ST_APPLY:         state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Close any open run against the best window so far; strictly longer wins.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (run_len_q[i] > best_len_q[i]) begin
        cls_start[i] = run_start_q[i];
        cls_len[i]   = run_len_q[i];
      end else begin
        cls_start[i] = best_start_q[i];
        cls_len[i]   = best_len_q[i];
      end
      apply_tap[i] = center_tap(cls_start[i], cls_len[i]);
    end
  end

  // Datapath next values: counters, per-tap pass accumulation, window records.
  always_comb begin
    sweep_d      = sweep_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    tap_d        = tap_q;

    unique case (state_q)
      ST_SET_TAP: begin
        cnt_d = '0;
        for (int i = 0; i < LANES; i++) tap_d[i] = sweep_q;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d  = '0;
          pass_d = '1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (sample_valid) begin
          pass_d = pass_q & sample_ok;
          cnt_d  = (cnt_q == SAMPLE_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
      end
      ST_UPDATE: begin
        for (int i = 0; i < LANES; i++) begin
          if (pass_q[i]) begin
            if (run_len_q[i] == '0) run_start_d[i] = sweep_q;
            run_len_d[i] = run_len_q[i] + RUN_W'(1);
          end else begin
            if (run_len_q[i] > best_len_q[i]) begin
              best_start_d[i] = run_start_q[i];
              best_len_d[i]   = run_len_q[i];
            end
            run_len_d[i] = '0;
          end
        end
        if (sweep_q != MAX_TAP) sweep_d = sweep_q + TAP_W'(1);
      end
      ST_APPLY: begin
        for (int i = 0; i < LANES; i++) begin
          best_start_d[i] = cls_start[i];
          best_len_d[i]   = cls_len[i];
          run_len_d[i]    = '0;
          tap_d[i]        = apply_tap[i];
          fail_d[i]       = (cls_len[i] == '0);
        end
      end
      default: ;
    endcase

    if (clear_rec) begin
      sweep_d = '0;
      cnt_d   = '0;
      pass_d  = '0;
      for (int i = 0; i < LANES; i++) begin
        run_start_d[i]  = '0;
        run_len_d[i]    = '0;
        best_start_d[i] = '0;
        best_len_d[i]   = '0;
      end
    end
    if (start_cal) fail_d = '0;
  end

  // Outputs: load strobes only in SET_TAP and APPLY, otherwise hold the registered taps.
  always_comb begin
    tap_value = '0;
    tap_load  = '0;
    busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done      = (state_q == ST_DONE);
    fail      = fail_q;
    for (int i = 0; i < LANES; i++) begin
      unique case (state_q)
        ST_SET_TAP: tap_value[i*TAP_W +: TAP_W] = sweep_q;
        ST_APPLY:   tap_value[i*TAP_W +: TAP_W] = apply_tap[i];
        default:    tap_value[i*TAP_W +: TAP_W] = tap_q[i];
      endcase
    end
    if ((state_q == ST_SET_TAP) || (state_q == ST_APPLY)) tap_load = '1;
  end

endmodule

// File: tb/tb_rgmii_idelay_tuner.sv
// Scoreboard bench for rgmii_idelay_tuner: a responder plays back per-lane pass
// tables against the swept tap, the stimulus pushes the expected calibration
// result per start, and a monitor scores each completed calibration.
module tb_rgmii_idelay_tuner;

  localparam int LANES = 5;
  localparam int TAP_W = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    dly_rdy;
  logic                    sample_valid;
  logic [LANES-1:0]        sample_ok;
  logic [LANES*TAP_W-1:0]  tap_value;
  logic [LANES-1:0]        tap_load;
  logic                    busy;
  logic                    done;
  logic [LANES-1:0]        fail;

  always #5 clk = ~clk;

  rgmii_idelay_tuner #(
    .LANES(5), .TAP_W(5), .SETTLE_CYCLES(4), .SAMPLE_CNT(8), .DEFAULT_TAP(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dly_rdy(dly_rdy),
    .sample_valid(sample_valid), .sample_ok(sample_ok),
    .tap_value(tap_value), .tap_load(tap_load),
    .busy(busy), .done(done), .fail(fail)
  );

  typedef struct {
    logic [24:0] taps;
    logic [4:0]  fl;
    int          loads;
    int          zeros;
    int          min_i;
    int          max_i;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Responder configuration
  logic [31:0] pass_tbl [LANES];
  int          glitch_mode;
  bit          abort_armed;
  int          cur_tap;
  int          k;
  int          abort_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [24:0] pk(input int t0, input int t1, input int t2,
                                     input int t3, input int t4);
    logic [24:0] v;
    v = {5'(t4), 5'(t3), 5'(t2), 5'(t1), 5'(t0)};
    return v;
  endfunction

  function automatic exp_t mk(input logic [24:0] taps, input logic [4:0] fl,
                              input int loads, input int zeros, input int mn, input int mx);
    exp_t e;
    e.taps = taps; e.fl = fl; e.loads = loads; e.zeros = zeros; e.min_i = mn; e.max_i = mx;
    return e;
  endfunction

  // Responder: follows the swept tap and answers with the per-lane pass tables.
  initial begin
    forever begin
      @(negedge clk);
      if (tap_load == 5'b11111) begin
        cur_tap = int'(tap_value[4:0]);
        k = 0;
      end else begin
        k++;
      end
      if (abort_cnt > 0) begin
        abort_cnt--;
        if (abort_cnt == 0) dly_rdy = 1'b1;
      end else if (abort_armed && cur_tap == 9 && k == 3) begin
        dly_rdy     = 1'b0;
        abort_cnt   = 3;
        abort_armed = 1'b0;
      end
      sample_valid = 1'b1;
      for (int i = 0; i < LANES; i++) sample_ok[i] = pass_tbl[i][cur_tap];
      if (glitch_mode != 0 && cur_tap == 7 && k == 7) begin
        sample_ok[4] = 1'b0;
        sample_valid = (glitch_mode == 2);
      end
    end
  end

  // Monitor: gathers load-strobe statistics and scores each completed calibration.
  initial begin
    int          loads, zeros, min_i, max_i, last_cyc, cyc, iv;
    bit          pend;
    logic [24:0] pend_tap;
    logic        busy_p, done_p;
    exp_t        e;
    loads = 0; zeros = 0; min_i = 32'h7fffffff; max_i = 0; last_cyc = -1; cyc = 0;
    pend = 1'b0; pend_tap = '0; busy_p = 1'b0; done_p = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && busy_p === 1'b0) begin
        loads = 0; zeros = 0; min_i = 32'h7fffffff; max_i = 0; last_cyc = -1; pend = 1'b0;
      end
      if (tap_load == 5'b11111) begin
        if (pend && pend_tap[4:0] == 5'd0) zeros++;
        if (last_cyc >= 0) begin
          iv = cyc - last_cyc;
          if (iv < min_i) min_i = iv;
          if (iv > max_i) max_i = iv;
        end
        last_cyc = cyc;
        loads++;
        pend     = 1'b1;
        pend_tap = tap_value;
      end
      if (done === 1'b1 && done_p === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("done_taps",     64'(tap_value), 64'(e.taps));
          chk("done_fail",     64'(fail),      64'(e.fl));
          chk("apply_taps",    64'(pend_tap),  64'(e.taps));
          chk("load_pulses",   64'(loads),     64'(e.loads));
          chk("tap0_loads",    64'(zeros),     64'(e.zeros));
          chk("min_tap_cycles", 64'(min_i),    64'(e.min_i));
          chk("max_tap_cycles", 64'(max_i),    64'(e.max_i));
        end
      end
      busy_p = busy;
      done_p = done;
    end
  end

  task automatic set_all_pass();
    for (int i = 0; i < LANES; i++) pass_tbl[i] = 32'hFFFF_FFFF;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({nm, "_done_reached"}, 64'(got), 64'(1));
  endtask

  // Stimulus: directed calibration scenarios with hand-computed results.
  initial begin
    logic [24:0] all15;
    bit          seen;
    all15 = pk(15, 15, 15, 15, 15);
    rst = 1'b1; start = 1'b0; dly_rdy = 1'b1; sample_valid = 1'b1; sample_ok = '1;
    glitch_mode = 0; abort_armed = 1'b0; abort_cnt = 0; cur_tap = 0; k = 0;
    set_all_pass();
    repeat (3) @(negedge clk);
    chk("rst_tap_value", 64'(tap_value), 64'(0));
    chk("rst_tap_load",  64'(tap_load),  64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_done",      64'(done),      64'(0));
    chk("rst_fail",      64'(fail),      64'(0));
    rst = 1'b0;
    @(negedge clk);

    // All lanes pass everywhere; a start while busy must be ignored.
    exp_q.push_back(mk(all15, 5'b00000, 33, 1, 14, 14));
    pulse_start();
    repeat (30) @(negedge clk);
    chk("busy_mid_sweep", 64'(busy), 64'(1));
    pulse_start();
    wait_done("all_pass");
    for (int r = 0; r < 3; r++) begin
      repeat (7) @(negedge clk);
      chk("hold_taps", 64'(tap_value), 64'(all15));
      chk("hold_done", 64'(done),      64'(1));
      chk("hold_load", 64'(tap_load),  64'(0));
    end

    // Windows: centre, earliest longest, never passing, run closed at max tap.
    pass_tbl[0] = 32'h001F_FC00;
    pass_tbl[1] = 32'h0000_7038;
    pass_tbl[2] = 32'h0000_0000;
    pass_tbl[3] = 32'hF000_0000;
    pass_tbl[4] = 32'hFFFF_FFFF;
    exp_q.push_back(mk(pk(15, 4, 0, 29, 15), 5'b00100, 33, 1, 14, 14));
    pulse_start();
    wait_done("windows");

    // Mismatch without sample_valid at tap 7 is ignored.
    set_all_pass();
    glitch_mode = 1;
    exp_q.push_back(mk(all15, 5'b00000, 33, 1, 14, 15));
    pulse_start();
    wait_done("glitch_invalid");

    // Qualified mismatch at tap 7 splits lane 4 into 0..6 and 8..31.
    glitch_mode = 2;
    exp_q.push_back(mk(pk(15, 15, 15, 15, 19), 5'b00000, 33, 1, 14, 14));
    pulse_start();
    wait_done("glitch_valid");
    glitch_mode = 0;

    // Delay controller drops at tap 9: sweep restarts from tap 0.
    abort_armed = 1'b1;
    exp_q.push_back(mk(all15, 5'b00000, 43, 2, 7, 14));
    pulse_start();
    wait_done("abort");

    // Reset mid-sweep at tap 20.
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (busy && cur_tap == 20) seen = 1'b1;
    end
    chk("reach_tap20", 64'(seen), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tap_value", 64'(tap_value), 64'(0));
    chk("midrst_tap_load",  64'(tap_load),  64'(0));
    chk("midrst_busy",      64'(busy),      64'(0));
    chk("midrst_done",      64'(done),      64'(0));
    chk("midrst_fail",      64'(fail),      64'(0));
    repeat (5) @(negedge clk);
    chk("midrst_idle_busy", 64'(busy), 64'(0));

    // Single-tap windows at both ends of the sweep.
    set_all_pass();
    pass_tbl[1] = 32'h0000_0001;
    pass_tbl[4] = 32'h8000_0000;
    exp_q.push_back(mk(pk(15, 0, 15, 15, 31), 5'b00000, 33, 1, 14, 14));
    pulse_start();
    wait_done("single_tap");

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
